// File: rtl/fetch_decode.sv
// rtl/fetch_decode.sv - instruction fetch with req/ack memory read and field-split output register
module fetch_decode #(
    parameter int              ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [3:0]      HALT_OP  = 4'hF
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [19:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [3:0]        opcode,
    output logic [3:0]        rd,
    output logic [3:0]        rs,
    output logic [7:0]        imm8,
    output logic              halted
);

    typedef enum logic [2:0] {BOOT, FETCH, DRAIN, HOLD, HALTED} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   pc;
    logic [19:0]         word;

    assign opcode = word[19:16];
    assign rd     = word[15:12];
    assign rs     = word[11:8];
    assign imm8   = word[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BOOT;
            pc        <= RESET_PC;
            imem_addr <= RESET_PC;
            imem_req  <= 1'b0;
            out_valid <= 1'b0;
            halted    <= 1'b0;
            word      <= '0;
            out_pc    <= '0;
        end else if (redirect_valid) begin
            pc        <= redirect_pc;
            out_valid <= 1'b0;
            imem_req  <= 1'b1;
            halted    <= 1'b0;
            // An unacked request must still complete, so its address is kept and the ack drained.
            if (state == DRAIN || (state == FETCH && !imem_ack)) begin
                state <= DRAIN;
            end else begin
                state     <= FETCH;
                imem_addr <= redirect_pc;
            end
        end else begin
            case (state)
                BOOT: begin
                    state     <= FETCH;
                    imem_addr <= pc;
                    imem_req  <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack) begin
                        word      <= imem_rdata;
                        out_pc    <= imem_addr;
                        pc        <= pc + 1'b1;
                        out_valid <= 1'b1;
                        imem_req  <= 1'b0;
                        state     <= HOLD;
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        imem_addr <= pc;
                        state     <= FETCH;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (word[19:16] == HALT_OP) begin
                            halted <= 1'b1;
                            state  <= HALTED;
                        end else begin
                            imem_addr <= pc;
                            imem_req  <= 1'b1;
                            state     <= FETCH;
                        end
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state    <= BOOT;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/fetch_decode.md
# fetch_decode

Instruction fetch and field-split stage of the 20-bit datapath. It walks the program counter, runs a request/acknowledge read against instruction memory, and holds the fetched 20-bit word in an output register behind a valid/ready handshake. The register drives opcode, register fields and the 8-bit immediate; the immediate feeds the `unextended` input of the zero-extension stage directly downstream. Branch redirects squash in-flight work, and a HALT opcode parks the stage.

## Interface
- `ADDR_W`, 8, instruction address width; PC wraps modulo 2^ADDR_W
- `RESET_PC`, 0, first fetch address after reset
- `HALT_OP`, 4'hF, opcode that stops fetching after it is delivered

- `clk` in 1 — single clock, all state on rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `imem_req` out 1 — read request, held high until `imem_ack`
- `imem_addr` out ADDR_W — read address, stable while `imem_req` is high
- `imem_ack` in 1 — read data valid this cycle; only meaningful while `imem_req` is high
- `imem_rdata` in 20 — instruction word, sampled when `imem_ack` is high
- `redirect_valid` in 1 — one-cycle pulse: load new PC and squash
- `redirect_pc` in ADDR_W — redirect target
- `out_valid` out 1 — decoded instruction available
- `out_ready` in 1 — consumer accepts when `out_valid && out_ready`
- `out_pc` out ADDR_W — address of the held instruction
- `opcode` out 4 — word[19:16]
- `rd` out 4 — word[15:12]
- `rs` out 4 — word[11:8]
- `imm8` out 8 — word[7:0]; connects to the zero-extender's `unextended`
- `halted` out 1 — stage is parked in HALTED

## Operation
- **States:** BOOT, FETCH, DRAIN, HOLD, HALTED.
- **Registers:** `pc` (next address to fetch), `imem_addr` register, output register (word + `out_pc`).
- **Request line:** `imem_req` is high exactly in FETCH and DRAIN.
- **BOOT → FETCH:** unconditional. Load `imem_addr` = `pc`.
- **FETCH, `imem_ack` without redirect:**
  - load output register from `imem_rdata`; `out_pc` = `imem_addr`
  - `pc` += 1 (wrapping); `out_valid` = 1; go to HOLD
- **HOLD:**
  - On handshake, `out_valid` falls next cycle.
  - If the held opcode == `HALT_OP`, go to HALTED; otherwise go to FETCH with `imem_addr` = `pc`.
  - Without handshake, the output register and `out_valid` stay stable.
- **HALTED:** no requests are issued; `halted` = 1. Only a redirect leaves this state.
- **Redirect (`redirect_valid` = 1).** It has priority over every other event in the same cycle.
  - `pc` = `redirect_pc`; `out_valid` = 0 (a simultaneous handshake still counts as consumed).
  - FETCH with no ack this cycle → DRAIN. `imem_addr` keeps the squashed address, so the request is completed.
  - FETCH with ack this cycle → data discarded; go to FETCH with `imem_addr` = `redirect_pc`.
  - HOLD or HALTED → FETCH with `imem_addr` = `redirect_pc`.
  - DRAIN → stay in DRAIN; only `pc` is updated.
  - BOOT → FETCH with `imem_addr` = `redirect_pc`.
- **DRAIN:** on `imem_ack`, discard data and go to FETCH with `imem_addr` = `pc`.
- **Field split:** purely positional slicing; no sign handling.

## Timing
- **Reset values:**
  - state BOOT; `pc` = `imem_addr` = `RESET_PC`
  - `imem_req` = 0, `out_valid` = 0, `halted` = 0
  - `out_pc`, `opcode`, `rd`, `rs`, `imm8` = 0
- **Start-up:** `imem_req` rises at the first rising edge after `rst_n` deasserts.
- **Ack timing:** `imem_ack` may arrive in the first cycle `imem_req` is high (zero wait) or any later cycle.
- **Fetch latency:** `out_valid` rises at the edge that samples `imem_ack`.
- **Throughput:** at most one instruction per 2 cycles with zero-wait memory (FETCH, HOLD alternate).
- **Reset mid-operation:**
  - `rst_n` low returns all state to reset values immediately (asynchronous).
  - An ack outstanding at that moment is dropped.
  - Memory must not ack while `imem_req` is low.
- **PC wrap:** `pc` = 2^ADDR_W − 1 increments to 0; no flag.

## Test plan
- **Zero-wait fetch:** reset release, memory returns 20'h1_2_3_17 at addr 0 with ack in the same cycle, `out_ready` = 1. Required: `out_valid` one cycle, `opcode` = 1, `rd` = 2, `rs` = 3, `imm8` = 8'h17, `out_pc` = 0; next request at addr 1.
- **Backpressure:** `out_ready` = 0 for 5 cycles with `imm8` = 8'hD8 held. Required: outputs stable, `imem_req` low throughout; next fetch begins the cycle after `out_ready` rises.
- **Redirect during wait:** ack delayed 3 cycles, redirect to 8'h40 on cycle 1 of the wait. Required: state DRAIN, `imem_addr` held at the old address until ack, that data never appears on the outputs, then a request at 8'h40.
- **Redirect with simultaneous ack, and PC wrap:**
  - Redirect and ack in the same FETCH cycle: data discarded, next `imem_addr` = `redirect_pc`.
  - Fetch at 8'hFF: the following request goes to 8'h00.
- **HALT:** word 20'hF_0_0_00 delivered and accepted. Required: `halted` = 1, no `imem_req` for 10 cycles; redirect to 8'h10 → `halted` = 0, request at 8'h10.
- **Async reset:** `rst_n` low mid-HOLD with `imm8` = 8'h54. Required: all outputs zero with no clock edge, then BOOT → FETCH at `RESET_PC`.
